cascade_div: RTL and testbench

Parametrised cascaded frequency divider for the stopwatch/counter datapath. It divides `clk` through `N_STAGE` chained stages with individually set ratios. Each stage produces a one-cycle tick (clock enable), a square wave and its live count. The block runs entirely on `clk` with a synchronous run/hold, so it never gates the clock. It adds single-step and synchronous clear, so downstream display and timekeeping logic can be stepped and zeroed cleanly.

---
 rtl/cascade_div.sv | 77 +++++++
 tb/tb_cascade_div.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cascade_div.sv
// Cascaded frequency divider: N_STAGE synchronous counters chained by a
// ripple-free carry, each exposing its count, a wrap tick and a square wave.
module cascade_div #(
  parameter int                      N_STAGE = 5,
  parameter int                      CW      = 16,
  parameter logic [N_STAGE*CW-1:0]   RATIO   = {16'd6, 16'd6, 16'd10, 16'd10, 16'd10}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    step,
  input  logic                    clr,
  output logic [N_STAGE-1:0]      tick,
  output logic [N_STAGE-1:0]      sq,
  output logic [N_STAGE*CW-1:0]   cnt
);

  logic                adv;
  logic [N_STAGE-1:0]  at_max;
  logic [N_STAGE-1:0]  en;
  logic [N_STAGE-1:0]  wrap;

  // Clear suppresses advancing so a same-edge wrap cannot raise a tick.
  assign adv = ~clr & (run | step);

  for (genvar k = 0; k < N_STAGE; k++) begin : g_stage
    // A ratio field of 0 stands for 2^CW; R_MAX then wraps to all ones.
    localparam logic [CW-1:0] R_FIELD = RATIO[k*CW +: CW];
    localparam logic [CW:0]   R_FULL  = (R_FIELD == '0) ? {1'b1, {CW{1'b0}}}
                                                        : {1'b0, R_FIELD};
    localparam logic [CW-1:0] R_MAX   = R_FIELD - CW'(1);
    localparam logic [CW-1:0] HALF    = R_FULL[CW:1];

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          tick_q;
    logic          sq_q;

    assign at_max[k] = (count_q == R_MAX);

    // Carry is the AND of all lower terminal counts, not a chain of stage
    // outputs, so every wrapping stage moves on the same edge.
    if (k == 0) begin : g_first
      assign en[k] = adv;
    end else begin : g_carry
      assign en[k] = adv & (&at_max[k-1:0]);
    end

    assign wrap[k] = en[k] & at_max[k];
    assign count_d = wrap[k] ? '0
                   : en[k]   ? count_q + CW'(1)
                   :           count_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge counts of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        count_q <= '0;
        tick_q  <= 1'b0;
        sq_q    <= 1'b0;
      end else if (clr) begin
        count_q <= '0;
        tick_q  <= 1'b0;
        sq_q    <= 1'b0;
      end else begin
        count_q <= count_d;
        tick_q  <= wrap[k];
        sq_q    <= (count_d >= HALF);
      end
    end

    assign cnt[k*CW +: CW] = count_q;
    assign tick[k]         = tick_q;
    assign sq[k]           = sq_q;
  end

endmodule

// File: tb/tb_cascade_div.sv
// Directed bench for cascade_div: default ratios (10,10,10,6,6) and a copy
// with stage 0 overridden to 3, both driven by the same controls.
`timescale 1ns/1ps
module tb_cascade_div;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic        clr;
  logic [4:0]  tick_a, sq_a, tick_b, sq_b;
  logic [79:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  int r_a[5] = '{10, 10, 10, 6, 6};
  int r_b[5] = '{3, 10, 10, 6, 6};

  cascade_div dut_a (
    .clk(clk), .rst(rst), .run(run), .step(step), .clr(clr),
    .tick(tick_a), .sq(sq_a), .cnt(cnt_a)
  );

  cascade_div #(
    .N_STAGE(5), .CW(16),
    .RATIO({16'd6, 16'd6, 16'd10, 16'd10, 16'd3})
  ) dut_b (
    .clk(clk), .rst(rst), .run(run), .step(step), .clr(clr),
    .tick(tick_b), .sq(sq_b), .cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ratio(input bit b, input int k);
    return b ? r_b[k] : r_a[k];
  endfunction

  function automatic logic [79:0] exp_cnt(input bit b, input int p);
    logic [79:0] v;
    int div;
    v = '0;
    div = 1;
    for (int k = 0; k < 5; k++) begin
      v[k*16 +: 16] = 16'((p / div) % ratio(b, k));
      div = div * ratio(b, k);
    end
    return v;
  endfunction

  function automatic logic [4:0] exp_sq(input bit b, input int p);
    logic [4:0] v;
    int div;
    v = '0;
    div = 1;
    for (int k = 0; k < 5; k++) begin
      v[k] = ((p / div) % ratio(b, k)) >= (ratio(b, k) / 2);
      div = div * ratio(b, k);
    end
    return v;
  endfunction

  function automatic logic [4:0] exp_tick(input bit b, input int p, input bit advanced);
    logic [4:0] v;
    int div;
    v = '0;
    div = 1;
    for (int k = 0; k < 5; k++) begin
      div = div * ratio(b, k);
      v[k] = advanced && (p > 0) && ((p % div) == 0);
    end
    return v;
  endfunction

  // One clock edge: predict from the controls, sample 1 ns after the edge.
  task automatic cycle(input string tag);
    bit a;
    bit c;
    c = clr;
    a = !clr && (run || step);
    @(posedge clk);
    #1;
    if (c) pos = 0;
    else if (a) pos++;
    check({tag, "_cnt_a"},  cnt_a,          exp_cnt(1'b0, pos));
    check({tag, "_tick_a"}, 80'(tick_a),    80'(exp_tick(1'b0, pos, a)));
    check({tag, "_sq_a"},   80'(sq_a),      80'(exp_sq(1'b0, pos)));
    check({tag, "_cnt_b"},  cnt_b,          exp_cnt(1'b1, pos));
    check({tag, "_tick_b"}, 80'(tick_b),    80'(exp_tick(1'b1, pos, a)));
    check({tag, "_sq_b"},   80'(sq_b),      80'(exp_sq(1'b1, pos)));
  endtask

  initial begin
    rst  = 1'b0;
    run  = 1'b0;
    step = 1'b0;
    clr  = 1'b0;
    #3;
    check("reset_cnt",  cnt_a,       80'h0);
    check("reset_tick", 80'(tick_a), 80'h0);
    check("reset_sq",   80'(sq_a),   80'h0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    run = 1'b1;

    // Free run through the full 36000-clock cycle of the chain.
    for (int n = 1; n <= 36000; n++) begin
      cycle("run");
      if (n == 10)    check("t10",    80'(tick_a), 80'(5'b00001));
      if (n == 100)   check("t100",   80'(tick_a), 80'(5'b00011));
      if (n == 1000)  check("t1000",  80'(tick_a), 80'(5'b00111));
      if (n == 6000)  check("t6000",  80'(tick_a), 80'(5'b01111));
      if (n == 35999) check("t35999", 80'(tick_a), 80'(5'b00000));
      if (n == 36000) begin
        check("t36000",   80'(tick_a), 80'(5'b11111));
        check("c36000",   cnt_a,       80'h0);
        check("sqb36000", 80'(sq_b[0]), 80'(1'b0));
      end
    end

    repeat (7) cycle("to7");
    check("cnt7", 80'(cnt_a[15:0]), 80'd7);

    run = 1'b0;
    repeat (20) cycle("hold");
    check("hold_cnt", 80'(cnt_a[15:0]), 80'd7);

    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      cycle("step");
      if (i == 0) check("step8", 80'(cnt_a[15:0]), 80'd8);
      if (i == 2) begin
        check("step_wrap_cnt",  80'(cnt_a[31:0]), 80'h0001_0000);
        check("step_wrap_tick", 80'(tick_a),      80'(5'b00001));
      end
      step = 1'b0;
      cycle("step_gap");
    end

    // step is ignored while run is high.
    run  = 1'b1;
    step = 1'b1;
    repeat (4) cycle("run_step");
    step = 1'b0;

    clr = 1'b1;
    cycle("clr0");
    clr = 1'b0;
    repeat (99) cycle("pre100");
    check("pre100_cnt", 80'(cnt_a[31:0]), 80'h0009_0009);
    clr = 1'b1;
    cycle("clr_wrap");
    check("clr_wrap_tick", 80'(tick_a), 80'h0);
    check("clr_wrap_cnt",  cnt_a,       80'h0);
    check("clr_wrap_sq",   80'(sq_a),   80'h0);
    clr = 1'b0;

    repeat (1234) cycle("to1234");
    check("cnt1234", cnt_a, 80'h0000_0001_0002_0003_0004);

    #2;
    rst = 1'b0;
    #1;
    pos = 0;
    check("arst_cnt_a",  cnt_a,       80'h0);
    check("arst_tick_a", 80'(tick_a), 80'h0);
    check("arst_sq_a",   80'(sq_a),   80'h0);
    check("arst_cnt_b",  cnt_b,       80'h0);
    #2;
    rst = 1'b1;
    cycle("restart");
    check("restart_cnt", cnt_a, 80'h1);
    repeat (12) cycle("restart_run");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
